// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and state encoding for the decode-stage hazard controller.
// Contents: REG_ADDRW, CPU_WIDTH, FSM state codes, pc+4 helper.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDRW = 5;
  localparam int CPU_WIDTH = 32;

  typedef logic [REG_ADDRW-1:0] regid_t;
  typedef logic [CPU_WIDTH-1:0] pc_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LDSTALL = 3'd1;
  localparam logic [2:0] S_F_DRAIN = 3'd2;
  localparam logic [2:0] S_F_INV   = 3'd3;
  localparam logic [2:0] S_F_REDIR = 3'd4;
  localparam logic [2:0] S_T_REDIR = 3'd5;

  // wraps at CPU_WIDTH
  function automatic pc_t pc_next(pc_t pc);
    return pc + CPU_WIDTH'(4);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between decode/execute/LSU/I-cache and the hazard controller.
// i_* flow into the controller (slave), o_* flow out of it.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic   i_idu_valid;
  regid_t i_idu_rs1id;
  regid_t i_idu_rs2id;
  logic   i_idu_fencei;
  logic   i_idu_ecall;
  logic   i_idu_mret;
  pc_t    i_idu_pc;
  logic   i_exu_valid;
  logic   i_exu_lden;
  regid_t i_exu_rdid;
  logic   i_lsu_busy;
  pc_t    i_mtvec;
  pc_t    i_mepc;
  logic   i_icache_inv_ack;

  logic   o_idu_stall;
  logic   o_exu_nop;
  logic   o_flush;
  logic   o_redirect_valid;
  pc_t    o_redirect_pc;
  logic   o_icache_inv_req;
  logic   o_inv_err;

  modport master (
    output i_idu_valid, i_idu_rs1id, i_idu_rs2id,
    output i_idu_fencei, i_idu_ecall, i_idu_mret,
    output i_idu_pc, i_exu_valid, i_exu_lden,
    output i_exu_rdid, i_lsu_busy, i_mtvec, i_mepc,
    output i_icache_inv_ack,
    input  o_idu_stall, o_exu_nop, o_flush,
    input  o_redirect_valid, o_redirect_pc,
    input  o_icache_inv_req, o_inv_err
  );

  modport slave (
    input  i_idu_valid, i_idu_rs1id, i_idu_rs2id,
    input  i_idu_fencei, i_idu_ecall, i_idu_mret,
    input  i_idu_pc, i_exu_valid, i_exu_lden,
    input  i_exu_rdid, i_lsu_busy, i_mtvec, i_mepc,
    input  i_icache_inv_ack,
    output o_idu_stall, o_exu_nop, o_flush,
    output o_redirect_valid, o_redirect_pc,
    output o_icache_inv_req, o_inv_err
  );

endinterface

// File: rtl/pipe_hazard_ctrl_ldcmp.sv
// Load-use comparator: flags a decode operand produced by a load in EXU.
// Ports: i_idu_valid, i_rs1id, i_rs2id, i_exu_valid, i_exu_lden, i_exu_rdid -> o_haz.
module pipe_hazard_ldcmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic   i_idu_valid,
  input  regid_t i_rs1id,
  input  regid_t i_rs2id,
  input  logic   i_exu_valid,
  input  logic   i_exu_lden,
  input  regid_t i_exu_rdid,
  output logic   o_haz
);

  logic w_hit;

  assign w_hit = (i_exu_rdid == i_rs1id) |
                 (i_exu_rdid == i_rs2id);

  // x0 is never a real dependency
  assign o_haz = i_idu_valid & i_exu_valid &
                 i_exu_lden & (i_exu_rdid != '0) &
                 w_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage sequencer: load-use bubbles, fence.i and ecall/mret redirects.
// Ports: i_clk, i_rst (async high), io_bus (slave bundle).
// Optional PIPE_HAZARD_CTRL_PERF_EN adds o_perf_stall_cnt/o_perf_flush_cnt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LDUSE_LAT   = 1,
  parameter int INV_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  pipe_hazard_ctrl_if.slave io_bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
`endif
);

  localparam logic [2:0] LAT_M1   = 3'(LDUSE_LAT - 1);
  localparam logic [7:0] TMO_LAST = 8'(INV_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_nxt;
  logic [2:0] r_cnt;
  logic [7:0] r_tcnt;
  pc_t        r_tgt;
  logic       r_err;

  logic w_haz, w_trap, w_fence, w_idle;
  logic w_redir, w_stall, w_tmo;

  pipe_hazard_ldcmp u_ldcmp (
    .i_idu_valid (io_bus.i_idu_valid),
    .i_rs1id     (io_bus.i_idu_rs1id),
    .i_rs2id     (io_bus.i_idu_rs2id),
    .i_exu_valid (io_bus.i_exu_valid),
    .i_exu_lden  (io_bus.i_exu_lden),
    .i_exu_rdid  (io_bus.i_exu_rdid),
    .o_haz       (w_haz)
  );

  assign w_trap  = io_bus.i_idu_valid &
                   (io_bus.i_idu_ecall | io_bus.i_idu_mret);
  assign w_fence = io_bus.i_idu_valid & io_bus.i_idu_fencei;
  assign w_idle  = (r_state == S_IDLE);
  assign w_redir = (r_state == S_F_REDIR) |
                   (r_state == S_T_REDIR);
  assign w_tmo   = (r_tcnt == TMO_LAST);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_trap)
          w_nxt = S_T_REDIR;
        else if (w_fence)
          w_nxt = S_F_DRAIN;
        else if (w_haz && LDUSE_LAT > 1)
          w_nxt = S_LDSTALL;
      end
      S_LDSTALL:
        if (r_cnt == 3'd1) w_nxt = S_IDLE;
      S_F_DRAIN:
        if (!io_bus.i_lsu_busy) w_nxt = S_F_INV;
      S_F_INV:
        if (io_bus.i_icache_inv_ack || w_tmo)
          w_nxt = S_F_REDIR;
      S_F_REDIR: w_nxt = S_IDLE;
      S_T_REDIR: w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // fence.i does not stall in its detect cycle; a trap does
  assign w_stall = (w_idle & (w_trap | (w_haz & ~w_fence))) |
                   (r_state == S_LDSTALL) |
                   (r_state == S_F_DRAIN) |
                   (r_state == S_F_INV);

  assign io_bus.o_idu_stall      = w_stall;
  assign io_bus.o_exu_nop        =
    (w_idle & w_haz & ~w_trap & ~w_fence) |
    (r_state == S_LDSTALL);
  assign io_bus.o_flush          = w_redir;
  assign io_bus.o_redirect_valid = w_redir;
  assign io_bus.o_redirect_pc    = w_redir ? r_tgt : '0;
  assign io_bus.o_icache_inv_req = (r_state == S_F_INV);
  assign io_bus.o_inv_err        = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_tgt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_trap)
            r_tgt <= io_bus.i_idu_ecall ?
                     io_bus.i_mtvec : io_bus.i_mepc;
          else if (w_fence)
            r_tgt <= pc_next(io_bus.i_idu_pc);
          else if (w_haz)
            r_cnt <= LAT_M1;
        end
        S_LDSTALL: r_cnt <= r_cnt - 3'd1;
        S_F_DRAIN: r_tcnt <= '0;
        S_F_INV: begin
          // an ack on the last cycle still wins
          if (!io_bus.i_icache_inv_ack && w_tmo)
            r_err <= 1'b1;
          else
            r_tcnt <= r_tcnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] r_pstall;
  logic [31:0] r_pflush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pstall <= '0;
      r_pflush <= '0;
    end else begin
      if (w_stall && r_pstall != '1)
        r_pstall <= r_pstall + 32'd1;
      if (w_redir && r_pflush != '1)
        r_pflush <= r_pflush + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_pstall;
  assign o_perf_flush_cnt = r_pflush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LDUSE_LAT=1/INV_TIMEOUT=255
// and LDUSE_LAT=3/INV_TIMEOUT=8) against a transaction-level model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic m_err [2];

  logic vld, fencei, ecall, mret;
  logic exv, lden, busy, ack;
  regid_t rs1, rs2, rdid;
  pc_t pc, mtvec, mepc;

  pipe_hazard_ctrl_if if_a ();
  pipe_hazard_ctrl_if if_b ();

  // only the selected instance sees a valid decode slot
  assign if_a.i_idu_valid = vld & (sel == 0);
  assign if_b.i_idu_valid = vld & (sel == 1);
  assign if_a.i_idu_rs1id = rs1;
  assign if_b.i_idu_rs1id = rs1;
  assign if_a.i_idu_rs2id = rs2;
  assign if_b.i_idu_rs2id = rs2;
  assign if_a.i_idu_fencei = fencei;
  assign if_b.i_idu_fencei = fencei;
  assign if_a.i_idu_ecall = ecall;
  assign if_b.i_idu_ecall = ecall;
  assign if_a.i_idu_mret = mret;
  assign if_b.i_idu_mret = mret;
  assign if_a.i_idu_pc = pc;
  assign if_b.i_idu_pc = pc;
  assign if_a.i_exu_valid = exv;
  assign if_b.i_exu_valid = exv;
  assign if_a.i_exu_lden = lden;
  assign if_b.i_exu_lden = lden;
  assign if_a.i_exu_rdid = rdid;
  assign if_b.i_exu_rdid = rdid;
  assign if_a.i_lsu_busy = busy;
  assign if_b.i_lsu_busy = busy;
  assign if_a.i_mtvec = mtvec;
  assign if_b.i_mtvec = mtvec;
  assign if_a.i_mepc = mepc;
  assign if_b.i_mepc = mepc;
  assign if_a.i_icache_inv_ack = ack;
  assign if_b.i_icache_inv_ack = ack;

  logic o_stall, o_nop, o_flush, o_rv, o_req, o_err;
  pc_t o_pc;
  assign o_stall = sel ? if_b.o_idu_stall : if_a.o_idu_stall;
  assign o_nop   = sel ? if_b.o_exu_nop : if_a.o_exu_nop;
  assign o_flush = sel ? if_b.o_flush : if_a.o_flush;
  assign o_rv    = sel ? if_b.o_redirect_valid : if_a.o_redirect_valid;
  assign o_pc    = sel ? if_b.o_redirect_pc : if_a.o_redirect_pc;
  assign o_req   = sel ? if_b.o_icache_inv_req : if_a.o_icache_inv_req;
  assign o_err   = sel ? if_b.o_inv_err : if_a.o_inv_err;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] pa_st, pa_fl, pb_st, pb_fl;
  longint e_pst [2];
  longint e_pfl [2];
`endif

  pipe_hazard_ctrl #(.LDUSE_LAT(1), .INV_TIMEOUT(255)) u_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if_a)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .o_perf_stall_cnt (pa_st),
    .o_perf_flush_cnt (pa_fl)
`endif
  );

  pipe_hazard_ctrl #(.LDUSE_LAT(3), .INV_TIMEOUT(8)) u_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if_b)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .o_perf_stall_cnt (pb_st),
    .o_perf_flush_cnt (pb_fl)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut %0d): observed %h expected %h",
             tag, sel, obs, exp);
    end
  endtask

  task automatic clear();
    vld = 0; fencei = 0; ecall = 0; mret = 0;
    exv = 0; lden = 0; busy = 0; ack = 0;
    rs1 = '0; rs2 = '0; rdid = '0;
    pc = '0; mtvec = '0; mepc = '0;
  endtask

  // check one cycle's outputs mid-cycle, then move past the next edge
  task automatic step(string tag, logic e_stall, logic e_nop,
                      logic e_rv, pc_t e_pc, logic e_req);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(o_stall), 32'(e_stall));
    chk({tag, ".nop"}, 32'(o_nop), 32'(e_nop));
    chk({tag, ".flush"}, 32'(o_flush), 32'(e_rv));
    chk({tag, ".rvalid"}, 32'(o_rv), 32'(e_rv));
    chk({tag, ".req"}, 32'(o_req), 32'(e_req));
    chk({tag, ".err"}, 32'(o_err), 32'(m_err[sel]));
    if (e_rv) chk({tag, ".rpc"}, o_pc, e_pc);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    e_pst[sel] += longint'(e_stall);
    e_pfl[sel] += longint'(e_rv);
`endif
    @(posedge clk);
    #1;
  endtask

  // a load-use hazard costs exactly LDUSE_LAT stalled cycles
  task automatic ldu(regid_t rd, regid_t r1, regid_t r2,
                     logic v, logic ev, logic ld);
    int lat;
    logic h;
    lat = sel ? 3 : 1;
    clear();
    rdid = rd; rs1 = r1; rs2 = r2;
    vld = v; exv = ev; lden = ld;
    h = v & ev & ld & (rd != 0) & (rd == r1 || rd == r2);
    step("ldu", h, h, 0, '0, 0);
    exv = 0;
    if (h)
      for (int k = 1; k < lat; k++) step("ldu_hold", 1, 1, 0, '0, 0);
    step("ldu_rel", 0, 0, 0, '0, 0);
    clear();
  endtask

  task automatic fence(pc_t fpc, int nbusy, int nreq,
                       bit tmo_case, bit hz);
    int tmo;
    tmo = sel ? 8 : 255;
    clear();
    vld = 1; fencei = 1; pc = fpc;
    if (hz) begin
      exv = 1; lden = 1;
      rdid = regid_t'($urandom_range(1, 31));
      rs1 = rdid;
    end
    busy = (nbusy > 0);
    step("fi_det", 0, 0, 0, '0, 0);
    for (int b = 0; b < nbusy; b++) step("fi_busy", 1, 0, 0, '0, 0);
    busy = 0;
    step("fi_drain", 1, 0, 0, '0, 0);
    if (tmo_case) begin
      for (int i = 0; i < tmo; i++) step("fi_tmo", 1, 0, 0, '0, 1);
      m_err[sel] = 1'b1;
    end else begin
      for (int i = 0; i < nreq; i++) begin
        ack = (i == nreq - 1);
        step("fi_inv", 1, 0, 0, '0, 1);
      end
    end
    ack = 0;
    step("fi_redir", 0, 0, 1, fpc + 32'd4, 0);
    clear();
    step("fi_after", 0, 0, 0, '0, 0);
  endtask

  task automatic trap(bit is_ecall, pc_t tv, bit also_fi,
                      bit hz, bit v);
    pc_t tgt;
    clear();
    mtvec = is_ecall ? tv : pc_t'($urandom);
    mepc  = is_ecall ? pc_t'($urandom) : tv;
    tgt = tv;
    vld = v; ecall = is_ecall; mret = !is_ecall;
    fencei = also_fi;
    if (hz) begin
      exv = 1; lden = 1;
      rdid = regid_t'($urandom_range(1, 31));
      rs2 = rdid;
    end
    if (v) begin
      step("tr_det", 1, 0, 0, '0, 0);
      clear();
      step("tr_redir", 0, 0, 1, tgt, 0);
      step("tr_after", 0, 0, 0, '0, 0);
    end else begin
      step("tr_novld", 0, 0, 0, '0, 0);
      clear();
      step("tr_novld2", 0, 0, 0, '0, 0);
    end
  endtask

  initial begin
    clear();
    m_err[0] = 0;
    m_err[1] = 0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    e_pst[0] = 0; e_pst[1] = 0;
    e_pfl[0] = 0; e_pfl[1] = 0;
`endif
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst.stall", 32'(o_stall), 32'd0);
      chk("rst.nop", 32'(o_nop), 32'd0);
      chk("rst.flush", 32'(o_flush), 32'd0);
      chk("rst.rvalid", 32'(o_rv), 32'd0);
      chk("rst.rpc", o_pc, 32'd0);
      chk("rst.req", 32'(o_req), 32'd0);
      chk("rst.err", 32'(o_err), 32'd0);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    sel = 0;
    ldu(5'd5, 5'd1, 5'd5, 1, 1, 1);
    ldu(5'd0, 5'd0, 5'd0, 1, 1, 1);
    sel = 1;
    ldu(5'd7, 5'd7, 5'd2, 1, 1, 1);
    ldu(5'd9, 5'd9, 5'd9, 0, 1, 1);

    sel = 0;
    fence(32'h8000_0010, 4, 3, 0, 0);
    sel = 1;
    fence(32'hFFFF_FFFC, 0, 8, 0, 1);
    fence(32'h8000_0200, 2, 0, 1, 0);
    fence(32'h8000_0300, 1, 1, 0, 1);

    sel = 0;
    trap(1, 32'h0000_0100, 0, 1, 1);
    sel = 1;
    trap(0, 32'h8000_0040, 0, 0, 1);
    trap(1, 32'h0000_0200, 1, 1, 1);

    for (int i = 0; i < 40; i++) begin
      regid_t rd, a, b;
      sel = int'($urandom_range(0, 1));
      rd = regid_t'($urandom);
      if ($urandom_range(0, 7) == 0) rd = '0;
      a = regid_t'($urandom);
      b = regid_t'($urandom);
      case ($urandom_range(0, 2))
        0: a = rd;
        1: b = rd;
        default: ;
      endcase
      ldu(rd, a, b, $urandom_range(0, 7) != 0,
          $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      fence(pc_t'($urandom) & ~32'h3, int'($urandom_range(0, 4)),
            int'($urandom_range(1, sel ? 8 : 4)), 0,
            1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 12; i++) begin
      sel = int'($urandom_range(0, 1));
      trap(1'($urandom_range(0, 1)), pc_t'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    sel = 0;
    chk("perf.stall", pa_st, 32'(e_pst[0]));
    chk("perf.flush", pa_fl, 32'(e_pfl[0]));
    sel = 1;
    chk("perf.stall", pb_st, 32'(e_pst[1]));
    chk("perf.flush", pb_fl, 32'(e_pfl[1]));
`endif

    // reset in the middle of an invalidate
    sel = 1;
    clear();
    vld = 1; fencei = 1; pc = 32'h8000_0100;
    step("mr_det", 0, 0, 0, '0, 0);
    step("mr_drain", 1, 0, 0, '0, 0);
    #2;
    chk("mr.req_before", 32'(o_req), 32'd1);
    rst = 1;
    m_err[0] = 0;
    m_err[1] = 0;
    #1;
    chk("mr.req", 32'(o_req), 32'd0);
    chk("mr.stall", 32'(o_stall), 32'd0);
    chk("mr.flush", 32'(o_flush), 32'd0);
    chk("mr.rvalid", 32'(o_rv), 32'd0);
    chk("mr.err", 32'(o_err), 32'd0);
    clear();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step("mr_after", 0, 0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
